// File: rtl/median_pkg.sv
// Shared types and sizing helpers for the median filter front end.
package median_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EMIT,
        S_GAP
    } state_t;

    localparam int unsigned WIN_SIZE = 9;
    localparam int unsigned K_W      = $clog2(WIN_SIZE);

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/median_window_feeder_line_buffer.sv
// One image row of pixels: combinational read, write on the clock edge,
// so a same-cycle read returns the previous row's value.
module line_buffer #(
    parameter int unsigned TAILLE = 8,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [TAILLE-1:0] wdata,
    output logic [TAILLE-1:0] rdata
);

    logic [TAILLE-1:0] mem [WIDTH];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/median_window_feeder.sv
// Buffers two rows of a raster pixel stream and serialises each interior
// 3x3 neighbourhood (row-major) onto DO/DSO for the median sorter.
module median_window_feeder
    import median_pkg::*;
#(
    parameter int unsigned TAILLE = 8,
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned HEIGHT = 16,
    parameter int unsigned GAP    = 40
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              IN_VALID,
    input  logic [TAILLE-1:0] IN_PIX,
    output logic              IN_RDY,
    output logic [TAILLE-1:0] DO,
    output logic              DSO,
    output logic              EOF
);

    localparam int unsigned CW = cnt_w(WIDTH);
    localparam int unsigned RW = cnt_w(HEIGHT);
    localparam int unsigned GW = cnt_w(GAP + 1);

    localparam logic [CW-1:0]  COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0]  ROW_LAST = RW'(HEIGHT - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [K_W-1:0] K_LAST   = K_W'(WIN_SIZE - 1);

    state_t            state, state_nx;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [K_W-1:0]    k;
    logic [GW-1:0]     gap_cnt;
    logic [TAILLE-1:0] win [WIN_SIZE];
    logic [TAILLE-1:0] lb1_q, lb2_q;
    logic              accept, win_ok, col_end, row_end;

    assign accept  = IN_VALID && IN_RDY;
    assign win_ok  = (row >= RW'(2)) && (col >= CW'(2));
    assign col_end = (col == COL_LAST);
    assign row_end = (row == ROW_LAST);

    line_buffer #(.TAILLE(TAILLE), .WIDTH(WIDTH), .AW(CW)) u_lb1 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (col),
        .wdata (IN_PIX),
        .rdata (lb1_q)
    );

    line_buffer #(.TAILLE(TAILLE), .WIDTH(WIDTH), .AW(CW)) u_lb2 (
        .CLK   (CLK),
        .we    (accept),
        .addr  (col),
        .wdata (lb1_q),
        .rdata (lb2_q)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept && win_ok) state_nx = S_EMIT;
            S_EMIT: if (k == K_LAST) state_nx = (GAP == 0) ? S_IDLE : S_GAP;
            S_GAP:  if (gap_cnt == GAP_LAST) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decode only registered state so reset clears DSO/DO at once.
    always_comb begin
        IN_RDY = (state == S_IDLE);
        DSO    = (state == S_EMIT);
        DO     = DSO ? win[k] : '0;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            col     <= '0;
            row     <= '0;
            k       <= '0;
            gap_cnt <= '0;
            EOF     <= 1'b0;
        end else begin
            k       <= (state == S_EMIT) ? k + 1'b1 : '0;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 1'b1 : '0;
            EOF     <= accept && col_end && row_end;
            if (accept) begin
                if (col_end) begin
                    col <= '0;
                    row <= row_end ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // Window shifts left; new right column is {row r-2, row r-1, row r}.
    always_ff @(posedge CLK) begin
        if (accept) begin
            win[0] <= win[1];
            win[1] <= win[2];
            win[2] <= lb2_q;
            win[3] <= win[4];
            win[4] <= win[5];
            win[5] <= lb1_q;
            win[6] <= win[7];
            win[7] <= win[8];
            win[8] <= IN_PIX;
        end
    end

endmodule

// File: tb/tb_median_window_feeder.sv
// Directed bench for median_window_feeder on a 4x4 image, with GAP=40 and GAP=0.
module tb_median_window_feeder;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;
    localparam int unsigned GA = 40;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [7:0] a_pix = '0, b_pix = '0;
    logic       a_rdy, b_rdy, a_dso, b_dso, a_eof, b_eof;
    logic [7:0] a_do, b_do;

    int total = 0;
    int bad = 0;

    logic [7:0] a_dq[$];
    int         a_len_q[$];
    int         a_run = 0;
    int         a_eof_cnt = 0;

    always #5 CLK = ~CLK;

    median_window_feeder #(.TAILLE(8), .WIDTH(W), .HEIGHT(H), .GAP(GA)) dut_a (
        .CLK(CLK), .nRST(nRST), .IN_VALID(a_valid), .IN_PIX(a_pix),
        .IN_RDY(a_rdy), .DO(a_do), .DSO(a_dso), .EOF(a_eof)
    );

    median_window_feeder #(.TAILLE(8), .WIDTH(W), .HEIGHT(H), .GAP(0)) dut_b (
        .CLK(CLK), .nRST(nRST), .IN_VALID(b_valid), .IN_PIX(b_pix),
        .IN_RDY(b_rdy), .DO(b_do), .DSO(b_dso), .EOF(b_eof)
    );

    // Records every DSO burst of dut_a (values and lengths) and EOF pulses.
    always @(negedge CLK) begin
        if (!nRST) begin
            a_run = 0;
        end else begin
            if (a_dso) begin
                a_dq.push_back(a_do);
                a_run++;
            end else if (a_run != 0) begin
                a_len_q.push_back(a_run);
                a_run = 0;
            end
            if (a_eof) a_eof_cnt++;
        end
    end

    // Pixel value at window position idx of the window accepted at (r,c).
    function automatic logic [7:0] win_exp(input int base, input int r, input int c, input int idx);
        return 8'(base + W * (r - 2 + idx / 3) + (c - 2 + idx % 3));
    endfunction

    task automatic send_a(input logic [7:0] p);
        int n;
        n = 0;
        a_valid = 1'b1;
        a_pix = p;
        while (!a_rdy && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (n >= 400) begin bad++; $display("FAIL send_a_timeout rdy=%b want 1", a_rdy); end
        @(negedge CLK);
        a_valid = 1'b0;
    endtask

    task automatic send_b(input logic [7:0] p);
        int n;
        n = 0;
        b_valid = 1'b1;
        b_pix = p;
        while (!b_rdy && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (n >= 400) begin bad++; $display("FAIL send_b_timeout rdy=%b want 1", b_rdy); end
        @(negedge CLK);
        b_valid = 1'b0;
    endtask

    task automatic drain_a();
        int n;
        n = 0;
        while (!a_rdy && n < 400) begin @(negedge CLK); n++; end
        total++;
        if (n >= 400) begin bad++; $display("FAIL drain_timeout rdy=%b want 1", a_rdy); end
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        repeat (3) @(negedge CLK);
        total++; if (a_dso !== 1'b0) begin bad++; $display("FAIL reset_dso got %b want 0", a_dso); end
        total++; if (a_do !== 8'd0) begin bad++; $display("FAIL reset_do got %0d want 0", a_do); end
        total++; if (a_eof !== 1'b0) begin bad++; $display("FAIL reset_eof got %b want 0", a_eof); end
        nRST = 1'b1;
        @(negedge CLK);
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_a got %b want 1", a_rdy); end
        total++; if (b_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy_b got %b want 1", b_rdy); end
        total++; if (b_dso !== 1'b0) begin bad++; $display("FAIL reset_dso_b got %b want 0", b_dso); end
    endtask

    task automatic test_border();
        for (int p = 0; p < 10; p++) begin
            total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL border_rdy px=%0d got %b want 1", p, a_rdy); end
            total++; if (a_dso !== 1'b0) begin bad++; $display("FAIL border_dso px=%0d got %b want 0", p, a_dso); end
            a_valid = 1'b1;
            a_pix = 8'(p);
            @(negedge CLK);
        end
    endtask

    task automatic test_first_window();
        int e1[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int e2[9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL win1_pre_rdy got %b want 1", a_rdy); end
        total++; if (a_dso !== 1'b0) begin bad++; $display("FAIL win1_pre_dso got %b want 0", a_dso); end
        a_valid = 1'b1;
        a_pix = 8'd10;
        @(negedge CLK);
        a_pix = 8'd11;
        for (int i = 0; i < 9; i++) begin
            total++; if (a_dso !== 1'b1) begin bad++; $display("FAIL win1_dso k=%0d got %b want 1", i, a_dso); end
            total++; if (a_do !== 8'(e1[i])) begin bad++; $display("FAIL win1_do k=%0d got %0d want %0d", i, a_do, e1[i]); end
            total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL win1_rdy k=%0d got %b want 0", i, a_rdy); end
            @(negedge CLK);
        end
        for (int i = 0; i < int'(GA); i++) begin
            total++; if (a_rdy !== 1'b0) begin bad++; $display("FAIL gap_rdy cyc=%0d got %b want 0", i, a_rdy); end
            total++; if (a_do !== 8'd0 || a_dso !== 1'b0) begin bad++; $display("FAIL gap_out cyc=%0d got dso=%b do=%0d want 0/0", i, a_dso, a_do); end
            @(negedge CLK);
        end
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL gap_end_rdy got %b want 1", a_rdy); end
        @(negedge CLK);
        a_valid = 1'b0;
        for (int i = 0; i < 9; i++) begin
            total++; if (a_dso !== 1'b1) begin bad++; $display("FAIL win2_dso k=%0d got %b want 1", i, a_dso); end
            total++; if (a_do !== 8'(e2[i])) begin bad++; $display("FAIL win2_do k=%0d got %0d want %0d", i, a_do, e2[i]); end
            @(negedge CLK);
        end
    endtask

    task automatic test_frame_end();
        repeat (2) @(negedge CLK);
        a_dq.delete();
        a_len_q.delete();
        a_eof_cnt = 0;
        send_a(8'd12);
        send_a(8'd13);
        send_a(8'd14);
        send_a(8'd15);
        total++; if (a_eof !== 1'b1) begin bad++; $display("FAIL eof_pulse got %b want 1", a_eof); end
        total++; if (a_dso !== 1'b1) begin bad++; $display("FAIL eof_dso got %b want 1", a_dso); end
        @(negedge CLK);
        total++; if (a_eof !== 1'b0) begin bad++; $display("FAIL eof_width got %b want 0", a_eof); end
        drain_a();
        total++; if (a_dq.size() != 18) begin bad++; $display("FAIL frame1_count got %0d want 18", a_dq.size()); end
        for (int i = 0; i < 9; i++) begin
            total++; if (a_dq[i] !== win_exp(0, 3, 2, i)) begin bad++; $display("FAIL frame1_w3 k=%0d got %0d want %0d", i, a_dq[i], win_exp(0, 3, 2, i)); end
            total++; if (a_dq[9+i] !== win_exp(0, 3, 3, i)) begin bad++; $display("FAIL frame1_w4 k=%0d got %0d want %0d", i, a_dq[9+i], win_exp(0, 3, 3, i)); end
        end
        total++; if (a_len_q.size() != 2) begin bad++; $display("FAIL frame1_bursts got %0d want 2", a_len_q.size()); end
        total++; if (a_eof_cnt != 1) begin bad++; $display("FAIL frame1_eofs got %0d want 1", a_eof_cnt); end
    endtask

    task automatic test_second_frame();
        int wr[4] = '{2, 2, 3, 3};
        int wc[4] = '{2, 3, 2, 3};
        a_dq.delete();
        a_len_q.delete();
        a_eof_cnt = 0;
        for (int i = 0; i < 16; i++) send_a(8'(100 + i));
        drain_a();
        total++; if (a_dq.size() != 36) begin bad++; $display("FAIL frame2_count got %0d want 36", a_dq.size()); end
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 9; i++) begin
                total++;
                if (a_dq[9*w+i] !== win_exp(100, wr[w], wc[w], i)) begin
                    bad++;
                    $display("FAIL frame2_w%0d k=%0d got %0d want %0d", w, i, a_dq[9*w+i], win_exp(100, wr[w], wc[w], i));
                end
            end
        end
        total++; if (a_len_q.size() != 4) begin bad++; $display("FAIL frame2_bursts got %0d want 4", a_len_q.size()); end
        foreach (a_len_q[j]) begin
            total++; if (a_len_q[j] != 9) begin bad++; $display("FAIL frame2_len b=%0d got %0d want 9", j, a_len_q[j]); end
        end
        total++; if (a_eof_cnt != 1) begin bad++; $display("FAIL frame2_eofs got %0d want 1", a_eof_cnt); end
    endtask

    task automatic test_gap_zero();
        logic [7:0] exp_do;
        for (int i = 0; i < 10; i++) send_b(8'(i));
        total++; if (b_rdy !== 1'b1) begin bad++; $display("FAIL g0_pre_rdy got %b want 1", b_rdy); end
        b_valid = 1'b1;
        b_pix = 8'd10;
        @(negedge CLK);
        b_pix = 8'd11;
        for (int i = 0; i < 19; i++) begin
            if (i == 9) begin
                total++; if (b_dso !== 1'b0 || b_rdy !== 1'b1 || b_do !== 8'd0) begin bad++; $display("FAIL g0_idle got dso=%b rdy=%b do=%0d want 0/1/0", b_dso, b_rdy, b_do); end
            end else begin
                exp_do = (i < 9) ? win_exp(0, 2, 2, i) : win_exp(0, 2, 3, i - 10);
                total++; if (b_dso !== 1'b1 || b_rdy !== 1'b0) begin bad++; $display("FAIL g0_burst cyc=%0d got dso=%b rdy=%b want 1/0", i, b_dso, b_rdy); end
                total++; if (b_do !== exp_do) begin bad++; $display("FAIL g0_do cyc=%0d got %0d want %0d", i, b_do, exp_do); end
            end
            @(negedge CLK);
        end
        b_valid = 1'b0;
        total++; if (b_dso !== 1'b0) begin bad++; $display("FAIL g0_after got %b want 0", b_dso); end
    endtask

    task automatic test_reset_mid_emit();
        for (int i = 0; i < 11; i++) send_a(8'(50 + i));
        total++; if (a_dso !== 1'b1) begin bad++; $display("FAIL rme_first_dso got %b want 1", a_dso); end
        repeat (3) @(negedge CLK);
        total++; if (a_do !== win_exp(50, 2, 2, 3) || a_dso !== 1'b1) begin bad++; $display("FAIL rme_fourth got dso=%b do=%0d want 1/%0d", a_dso, a_do, win_exp(50, 2, 2, 3)); end
        nRST = 1'b0;
        #1;
        total++; if (a_dso !== 1'b0) begin bad++; $display("FAIL rme_dso got %b want 0", a_dso); end
        total++; if (a_do !== 8'd0) begin bad++; $display("FAIL rme_do got %0d want 0", a_do); end
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        total++; if (a_rdy !== 1'b1) begin bad++; $display("FAIL rme_rdy got %b want 1", a_rdy); end
        a_dq.delete();
        a_len_q.delete();
        for (int i = 0; i < 10; i++) send_a(8'(60 + i));
        @(negedge CLK);
        total++; if (a_dq.size() != 0) begin bad++; $display("FAIL rme_border got %0d want 0", a_dq.size()); end
        send_a(8'd70);
        drain_a();
        total++; if (a_dq.size() != 9) begin bad++; $display("FAIL rme_count got %0d want 9", a_dq.size()); end
        for (int i = 0; i < 9; i++) begin
            total++; if (a_dq[i] !== win_exp(60, 2, 2, i)) begin bad++; $display("FAIL rme_win k=%0d got %0d want %0d", i, a_dq[i], win_exp(60, 2, 2, i)); end
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_border();
        test_first_window();
        test_frame_end();
        test_second_frame();
        test_gap_zero();
        test_reset_mid_emit();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/median_window_feeder.md
Name: median_window_feeder

Overview:
- Upstream stage of the 3x3 median filter.
- Accepts a raster-order 8-bit pixel stream through a valid/ready handshake and buffers two previous image rows in line memories.
- For every interior pixel position, serialises the 3x3 neighbourhood onto DO with DSO high for exactly 9 consecutive cycles, which matches the filter's DSI/DI input protocol.
- After each window it holds off input for GAP cycles so the filter can finish sorting.

Parameters:
- TAILLE, 8: pixel width in bits.
- WIDTH, 16: image width in pixels; must be >= 3.
- HEIGHT, 16: image height in rows; must be >= 3.
- GAP, 40: minimum idle cycles between the last DSO cycle of one window and the first of the next; must be >= 0.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  input pixel valid.
- IN_PIX  in  TAILLE  input pixel, raster order, row 0 col 0 first.
- IN_RDY  out  1  block can accept a pixel this cycle.
- DO  out  TAILLE  serialised window pixel; connects to the filter's DI.
- DSO  out  1  window data strobe; connects to the filter's DSI.
- EOF  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset (asynchronous, active-low):
  - State returns to IDLE; col/row counters, k counter and gap counter clear to 0.
  - DO = 0, DSO = 0, EOF = 0.
  - IN_RDY = 1 once nRST is released.
  - Line-buffer and window-register contents are not reset; they are never emitted before being overwritten.
- Accept rule: a pixel is accepted on a rising edge where IN_VALID && IN_RDY. IN_RDY = (state == IDLE), decoded from registered state only.
- Per accepted pixel at (row r, col c):
  - Read lb1[c] (row r-1) and lb2[c] (row r-2).
  - Shift the 3x3 window one column left; the new right column is {lb2[c], lb1[c], IN_PIX} (top, middle, bottom).
  - Write lb2[c] <= lb1[c] and lb1[c] <= IN_PIX.
- Counter wrap:
  - c increments; at WIDTH-1 it wraps to 0 and r increments.
  - At r = HEIGHT-1 and c = WIDTH-1, both wrap to 0 and EOF pulses on the following cycle.
  - Window contents across row and frame boundaries are ignored, because validity gating excludes them.
- Window valid: accepted pixel has r >= 2 and c >= 2. The window is centred at (r-1, c-1). Borders produce no output, so there are (WIDTH-2)*(HEIGHT-2) windows per frame.
- FSM:
  - IDLE: accepted pixel with window valid -> EMIT with k = 0. Otherwise stay in IDLE.
  - EMIT: DSO = 1 and DO = win[k]. Order is row-major: top-left, top-mid, top-right, mid-left, ..., bottom-right. k counts 0..8; at k = 8 -> GAP (or IDLE if GAP = 0).
  - GAP: DSO = 0; counts GAP cycles, then -> IDLE.
- Timing:
  - Latency: pixel accepted at edge t gives first DSO cycle t+1 through t+9.
  - IN_RDY is low from t+1 to t+9+GAP inclusive.
  - DO is 0 whenever DSO = 0.
  - The window registers are stable throughout EMIT because no accept can occur.
- IN_VALID low in any state has no effect; IN_PIX is don't-care when not accepted.
- Reset mid-EMIT: DSO drops immediately (asynchronously). After release, the frame restarts at (0,0).

Decomposition:
- Package median_pkg:
  - state enum {IDLE, EMIT, GAP}.
  - Localparam WIN_SIZE = 9.
  - Counter width helpers via $clog2(WIDTH), $clog2(HEIGHT), $clog2(GAP+1).
- Sub-module line_buffer: WIDTH x TAILLE single-port memory with same-cycle read-before-write, instantiated twice.

Test Plan:
1. Reset mid-EMIT: drop nRST during the 4th DSO cycle -> DSO = 0 and DO = 0 within the same cycle. After release, IN_RDY = 1 and the next window needs 3 new rows.
2. WIDTH = 4, HEIGHT = 4, pixel value = 4r+c, IN_VALID always high -> after pixel 10 is accepted, DO over the next 9 cycles = 0,1,2,4,5,6,8,9,10 with DSO = 1.
3. Same stream -> IN_RDY low for 9+GAP cycles after pixel 10. Pixel 11 is accepted on the first IDLE cycle. Next DO sequence = 1,2,3,5,6,7,9,10,11.
4. Border suppression: pixels 0..9 (rows 0-1, row 2 cols 0-1) -> DSO never asserted and IN_RDY stays 1 throughout.
5. Full 4x4 frame followed by a second frame -> exactly 4 windows per frame; EOF pulses once, the cycle after pixel 15 is accepted. Second-frame windows contain only second-frame pixels.
6. GAP = 0 -> the next pixel is accepted on the edge immediately after the last DSO cycle, giving back-to-back 9-cycle DSO bursts separated by the one accept cycle.
